// File: rtl/pf_iod_lvds_rx_align_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pf_iod_lvds_rx_align_pkg
// Description : Shared types, constants and helpers for the LVDS RX lane
//               training/alignment sequencer and its TX-side counterpart.
// Revision    : 1.0 - initial release
// ============================================================================
package pf_iod_lvds_rx_align_pkg;

  // Sequencer states; the encoding is fixed so waveforms read consistently
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LANE_RST = 3'd1,
    ST_PAUSE    = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_COMPARE  = 3'd4,
    ST_SLIP     = 3'd5,
    ST_LOCKED   = 3'd6,
    ST_FAIL     = 3'd7
  } align_state_t;

  // Defaults shared with the TX-side trainer so both ends agree on the pattern
  localparam int         c_default_data_width    = 8;
  localparam logic [7:0] c_default_train_pattern = 8'h5C;
  localparam int         c_default_rst_cycles    = 16;
  localparam int         c_default_pause_cycles  = 4;
  localparam int         c_default_settle_cycles = 8;
  localparam int         c_default_match_count   = 4;

  // The timer is loaded with (cycles - 1), so it only has to hold max - 1
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage : pf_iod_lvds_rx_align_pkg
`default_nettype wire

// File: rtl/pf_iod_lvds_rx_align_timer.sv
`default_nettype none
// ============================================================================
// Module      : pf_iod_lvds_rx_align_timer
// Description : Loadable down-counter with a terminal-count flag, shared by
//               all fixed waits of the alignment sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module pf_iod_lvds_rx_align_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule : pf_iod_lvds_rx_align_timer
`default_nettype wire

// File: rtl/pf_iod_lvds_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pf_iod_lvds_rx_align_ctrl
// Description : Training and word-alignment sequencer for one LVDS RX lane:
//               lane reset, HS_IO_CLK pause, then bit-slip until the
//               deserialized word matches the training pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module pf_iod_lvds_rx_align_ctrl
  import pf_iod_lvds_rx_align_pkg::*;
#(
  parameter int                    DATA_WIDTH    = c_default_data_width,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = c_default_train_pattern,
  parameter int                    RST_CYCLES    = c_default_rst_cycles,
  parameter int                    PAUSE_CYCLES  = c_default_pause_cycles,
  parameter int                    SETTLE_CYCLES = c_default_settle_cycles,
  parameter int                    MATCH_COUNT   = c_default_match_count
) (
  input  logic                              FAB_CLK,
  input  logic                              RESET_N,
  input  logic                              START,
  input  logic [DATA_WIDTH-1:0]             RX_DATA,
  output logic                              LANE_RESET,
  output logic                              HS_IO_CLK_PAUSE,
  output logic                              RX_BIT_SLIP,
  output logic                              BUSY,
  output logic                              LOCKED,
  output logic                              FAIL,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   SLIP_CNT
);

  localparam int c_tmr_w   = timer_width(RST_CYCLES, PAUSE_CYCLES, SETTLE_CYCLES);
  localparam int c_slip_w  = $clog2(DATA_WIDTH + 1);
  localparam int c_match_w = (MATCH_COUNT < 2) ? 1 : $clog2(MATCH_COUNT + 1);

  localparam logic [c_tmr_w-1:0]   c_rst_load    = c_tmr_w'(RST_CYCLES - 1);
  localparam logic [c_tmr_w-1:0]   c_pause_load  = c_tmr_w'(PAUSE_CYCLES - 1);
  localparam logic [c_tmr_w-1:0]   c_settle_load = c_tmr_w'(SETTLE_CYCLES - 1);
  localparam logic [c_slip_w-1:0]  c_slip_max    = c_slip_w'(DATA_WIDTH);
  localparam logic [c_match_w-1:0] c_match_max   = c_match_w'(MATCH_COUNT);
  localparam logic [c_match_w-1:0] c_match_last  = c_match_w'(MATCH_COUNT - 1);

  align_state_t         r_state;
  align_state_t         w_next;
  logic                 w_tmr_load;
  logic [c_tmr_w-1:0]   w_tmr_val;
  logic                 w_tmr_done;
  logic                 w_match_clr;
  logic                 w_match_inc;
  logic                 w_slip_clr;
  logic                 w_slip_inc;
  logic                 w_word_ok;
  logic [c_match_w-1:0] r_match_cnt;
  logic [c_slip_w-1:0]  r_slip_cnt;

  assign w_word_ok = (RX_DATA == TRAIN_PATTERN);

  pf_iod_lvds_rx_align_timer #(
    .WIDTH (c_tmr_w)
  ) u_timer (
    .clk        (FAB_CLK),
    .rst_n      (RESET_N),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // State register
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode plus timer/counter control strobes
  always_comb begin
    w_next      = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_match_clr = 1'b0;
    w_match_inc = 1'b0;
    w_slip_clr  = 1'b0;
    w_slip_inc  = 1'b0;
    case (r_state)
      ST_IDLE, ST_LOCKED, ST_FAIL: begin
        if (START) begin
          w_next     = ST_LANE_RST;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_rst_load;
          w_slip_clr = 1'b1;
        end
      end
      ST_LANE_RST: begin
        if (w_tmr_done) begin
          w_next     = ST_PAUSE;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_pause_load;
        end
      end
      ST_PAUSE: begin
        if (w_tmr_done) begin
          w_next      = ST_SETTLE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_settle_load;
          w_match_clr = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_tmr_done) w_next = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (w_word_ok) begin
          w_match_inc = 1'b1;
          if (r_match_cnt == c_match_last) w_next = ST_LOCKED;
        end else if (r_slip_cnt < c_slip_max) begin
          w_next     = ST_SLIP;
          w_slip_inc = 1'b1;
        end else begin
          w_next = ST_FAIL;
        end
      end
      ST_SLIP: begin
        w_next      = ST_SETTLE;
        w_tmr_load  = 1'b1;
        w_tmr_val   = c_settle_load;
        w_match_clr = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Consecutive-match counter, saturating at the lock threshold
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N)                               r_match_cnt <= '0;
    else if (w_match_clr)                       r_match_cnt <= '0;
    else if (w_match_inc && r_match_cnt < c_match_max) r_match_cnt <= r_match_cnt + 1'b1;
  end

  // Slip counter; advances on the same edge the slip pulse is raised
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N)        r_slip_cnt <= '0;
    else if (w_slip_clr) r_slip_cnt <= '0;
    else if (w_slip_inc) r_slip_cnt <= r_slip_cnt + 1'b1;
  end

  // Registered outputs decoded from the next state so they align with it
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      LANE_RESET      <= 1'b1;
      HS_IO_CLK_PAUSE <= 1'b0;
      RX_BIT_SLIP     <= 1'b0;
      BUSY            <= 1'b0;
      LOCKED          <= 1'b0;
      FAIL            <= 1'b0;
    end else begin
      LANE_RESET      <= (w_next == ST_IDLE) || (w_next == ST_LANE_RST);
      HS_IO_CLK_PAUSE <= (w_next == ST_PAUSE);
      RX_BIT_SLIP     <= (w_next == ST_SLIP);
      BUSY            <= !((w_next == ST_IDLE) || (w_next == ST_LOCKED) ||
                           (w_next == ST_FAIL));
      LOCKED          <= (w_next == ST_LOCKED);
      FAIL            <= (w_next == ST_FAIL);
    end
  end

  assign SLIP_CNT = r_slip_cnt;

endmodule : pf_iod_lvds_rx_align_ctrl
`default_nettype wire

// File: tb/tb_pf_iod_lvds_rx_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pf_iod_lvds_rx_align_ctrl
// Description : Directed self-checking bench for the LVDS RX align sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pf_iod_lvds_rx_align_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] rx_data;
  logic       lane_reset;
  logic       hs_pause;
  logic       bit_slip;
  logic       busy;
  logic       locked;
  logic       fail;
  logic [3:0] slip_cnt;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int pulses;
  int first_pulse;
  int last_pulse;
  int min_gap;
  bit rot_mode = 1'b0;
  int offset   = 0;

  pf_iod_lvds_rx_align_ctrl dut (
    .FAB_CLK         (clk),
    .RESET_N         (reset_n),
    .START           (start),
    .RX_DATA         (rx_data),
    .LANE_RESET      (lane_reset),
    .HS_IO_CLK_PAUSE (hs_pause),
    .RX_BIT_SLIP     (bit_slip),
    .BUSY            (busy),
    .LOCKED          (locked),
    .FAIL            (fail),
    .SLIP_CNT        (slip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rotl(input logic [7:0] p, input int k);
    logic [7:0] r;
    r = p;
    for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge, track slip pulses,
  // and model the IOD rotating the word by one bit per slip
  task automatic tick();
    @(posedge clk);
    #1;
    n++;
    if (bit_slip) begin
      if (pulses == 0) first_pulse = n;
      else if (n - last_pulse < min_gap) min_gap = n - last_pulse;
      last_pulse = n;
      pulses++;
      if (rot_mode && offset > 0) offset--;
    end
    if (rot_mode) rx_data = rotl(8'h5C, offset);
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic pulse_start();
    start       = 1'b1;
    n           = 0;
    pulses      = 0;
    first_pulse = 0;
    last_pulse  = 0;
    min_gap     = 1000;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    rx_data = 8'h5C;
    pulses  = 0;
    min_gap = 1000;
    tick();
    tick();
    chk("rst_lane_reset", lane_reset, 1);
    chk("rst_pause", hs_pause, 0);
    chk("rst_slip", bit_slip, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fail", fail, 0);
    chk("rst_slip_cnt", slip_cnt, 0);
    reset_n = 1'b1;
    tick();
    chk("idle_lane_reset", lane_reset, 1);
    chk("idle_busy", busy, 0);

    // Already aligned: best-case lock at cycle 33
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_lane_reset_c1", lane_reset, 1);
    run_to(16);
    chk("t1_lane_reset_c16", lane_reset, 1);
    chk("t1_pause_c16", hs_pause, 0);
    tick();
    chk("t1_lane_reset_c17", lane_reset, 0);
    chk("t1_pause_c17", hs_pause, 1);
    run_to(20);
    chk("t1_pause_c20", hs_pause, 1);
    tick();
    chk("t1_pause_c21", hs_pause, 0);
    run_to(32);
    chk("t1_locked_c32", locked, 0);
    tick();
    chk("t1_locked_c33", locked, 1);
    chk("t1_busy_c33", busy, 0);
    chk("t1_slip_cnt", slip_cnt, 0);
    chk("t1_no_slips", pulses, 0);

    // START in LOCKED restarts; START while busy is ignored
    pulse_start();
    chk("t6_locked_drop", locked, 0);
    chk("t6_lane_reset", lane_reset, 1);
    run_to(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(16);
    chk("t6_lane_reset_c16", lane_reset, 1);
    tick();
    chk("t6_lane_reset_c17", lane_reset, 0);
    run_to(33);
    chk("t6_locked_c33", locked, 1);

    // Three slips required: word starts rotated by 3
    offset   = 3;
    rot_mode = 1'b1;
    rx_data  = rotl(8'h5C, 3);
    pulse_start();
    run_to(62);
    chk("t2_locked_c62", locked, 0);
    tick();
    chk("t2_locked_c63", locked, 1);
    chk("t2_slip_cnt", slip_cnt, 3);
    chk("t2_pulses", pulses, 3);
    chk("t2_first_pulse", first_pulse, 30);
    chk("t2_min_gap", min_gap, 10);
    rot_mode = 1'b0;
    rx_data  = 8'h5C;

    // START in LOCKED clears a nonzero SLIP_CNT and holds lane reset 16 cycles
    pulse_start();
    chk("t7_locked_drop", locked, 0);
    chk("t7_slip_cnt_clr", slip_cnt, 0);
    chk("t7_lane_reset", lane_reset, 1);
    run_to(16);
    chk("t7_lane_reset_c16", lane_reset, 1);
    tick();
    chk("t7_lane_reset_c17", lane_reset, 0);
    run_to(33);
    chk("t7_locked_c33", locked, 1);

    // Never matches: 8 slips then FAIL
    rx_data = 8'h00;
    pulse_start();
    run_to(109);
    chk("t3_fail_c109", fail, 0);
    chk("t3_busy_c109", busy, 1);
    tick();
    chk("t3_fail_c110", fail, 1);
    chk("t3_locked", locked, 0);
    chk("t3_busy", busy, 0);
    chk("t3_slip_cnt", slip_cnt, 8);
    chk("t3_pulses", pulses, 8);

    // Intermittent: 3 matches, mismatch on the would-be 4th, then clean
    rx_data = 8'h5C;
    pulse_start();
    chk("t4_fail_drop", fail, 0);
    run_to(32);
    rx_data = 8'h00;
    tick();
    chk("t4_slip_c33", bit_slip, 1);
    chk("t4_locked_c33", locked, 0);
    chk("t4_slip_cnt_c33", slip_cnt, 1);
    rx_data = 8'h5C;
    run_to(45);
    chk("t4_locked_c45", locked, 0);
    tick();
    chk("t4_locked_c46", locked, 1);
    chk("t4_slip_cnt", slip_cnt, 1);
    chk("t4_pulses", pulses, 1);

    // Reset during PAUSE, then retrain
    pulse_start();
    run_to(18);
    chk("t5_pause_c18", hs_pause, 1);
    reset_n = 1'b0;
    tick();
    chk("t5_rst_lane_reset", lane_reset, 1);
    chk("t5_rst_pause", hs_pause, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_slip_cnt", slip_cnt, 0);
    reset_n = 1'b1;
    tick();
    tick();
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_lane_reset", lane_reset, 1);
    pulse_start();
    chk("t5_busy", busy, 1);
    run_to(16);
    chk("t5_lane_reset_c16", lane_reset, 1);
    tick();
    chk("t5_pause_c17", hs_pause, 1);
    run_to(33);
    chk("t5_locked_c33", locked, 1);
    chk("t5_never_both", locked & fail, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pf_iod_lvds_rx_align_ctrl
`default_nettype wire
